sha256d_nonce_scheduler: RTL and testbench

- Sequences the double-SHA256 core (80-byte header in, `hash`/`done` out, restarted only through its active-low reset) across a nonce range.
- Per nonce: builds `core_block`, pulses the core reset, waits for `done`, compares the digest against a target.
- Stops on the first hit, on range exhaustion, on abort, or on a core timeout.
- Sits between the host/config register file and the hash core.

---
 rtl/sha256d_nonce_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_sha256d_nonce_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256d_nonce_scheduler.sv
// Nonce sweep controller for a double-SHA256 core: builds each 80-byte block,
// cycles the core through reset, and compares every digest against a target.
module sha256d_nonce_scheduler #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1023,
  parameter int TIMEOUT_W  = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [607:0] header,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  output logic         core_rst_n,
  output logic [639:0] core_block,
  input  logic [255:0] core_hash,
  input  logic         core_done,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         timeout_err,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  cur_nonce,
  output logic [31:0]  hashes_done
);

  typedef enum logic [1:0] {S_IDLE, S_RSTC, S_WAIT, S_CHECK} state_t;

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]      RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic is_hit(input logic [255:0] h, input logic [255:0] t);
    return h <= t;
  endfunction

  state_t               state_q, state_d;
  logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [607:0]         header_q, header_d;
  logic [31:0]          nonce_end_q, nonce_end_d;
  logic [255:0]         target_q, target_d;
  logic [31:0]          cur_nonce_q, cur_nonce_d;
  logic [31:0]          hashes_done_q, hashes_done_d;
  logic                 found_q, found_d;
  logic                 exhausted_q, exhausted_d;
  logic                 timeout_q, timeout_d;
  logic [31:0]          found_nonce_q, found_nonce_d;
  logic [255:0]         found_hash_q, found_hash_d;
  logic                 busy_q, busy_d;
  logic                 core_rst_n_q, core_rst_n_d;

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    header_d      = header_q;
    nonce_end_d   = nonce_end_q;
    target_d      = target_q;
    cur_nonce_d   = cur_nonce_q;
    hashes_done_d = hashes_done_q;
    found_d       = found_q;
    exhausted_d   = exhausted_q;
    timeout_d     = timeout_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    busy_d        = busy_q;

    // Abort beats everything else, including a digest arriving this cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            header_d      = header;
            nonce_end_d   = nonce_end;
            target_d      = target;
            cur_nonce_d   = nonce_start;
            hashes_done_d = '0;
            found_d       = 1'b0;
            exhausted_d   = 1'b0;
            timeout_d     = 1'b0;
            busy_d        = 1'b1;
            rst_cnt_d     = '0;
            state_d       = S_RSTC;
          end
        end
        S_RSTC: begin
          if (rst_cnt_q == RC_LAST) begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
          end else begin
            rst_cnt_d = rst_cnt_q + RC_W'(1);
          end
        end
        S_WAIT: begin
          // A done seen in the first cycle out of reset may be stale; skip it.
          if (core_done && (wait_cnt_q != '0)) begin
            state_d = S_CHECK;
          end else begin
            wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
            if (wait_cnt_d == TO_LIMIT) begin
              timeout_d = 1'b1;
              busy_d    = 1'b0;
              state_d   = S_IDLE;
            end
          end
        end
        S_CHECK: begin
          hashes_done_d = sat_inc32(hashes_done_q);
          if (is_hit(core_hash, target_q)) begin
            found_d       = 1'b1;
            found_nonce_d = cur_nonce_q;
            found_hash_d  = core_hash;
            busy_d        = 1'b0;
            state_d       = S_IDLE;
          end else if (cur_nonce_q == nonce_end_q) begin
            exhausted_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
          end else begin
            cur_nonce_d = cur_nonce_q + 32'd1;
            rst_cnt_d   = '0;
            state_d     = S_RSTC;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    core_rst_n_d = (state_d == S_WAIT) || (state_d == S_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      header_q      <= '0;
      nonce_end_q   <= '0;
      target_q      <= '0;
      cur_nonce_q   <= '0;
      hashes_done_q <= '0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      timeout_q     <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      busy_q        <= 1'b0;
      core_rst_n_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      header_q      <= header_d;
      nonce_end_q   <= nonce_end_d;
      target_q      <= target_d;
      cur_nonce_q   <= cur_nonce_d;
      hashes_done_q <= hashes_done_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      timeout_q     <= timeout_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      busy_q        <= busy_d;
      core_rst_n_q  <= core_rst_n_d;
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign core_block  = {header_q, cur_nonce_q};
  assign busy        = busy_q;
  assign found       = found_q;
  assign exhausted   = exhausted_q;
  assign timeout_err = timeout_q;
  assign found_nonce = found_nonce_q;
  assign found_hash  = found_hash_q;
  assign cur_nonce   = cur_nonce_q;
  assign hashes_done = hashes_done_q;

endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// Directed bench for sha256d_nonce_scheduler with a behavioural hash core
// (full double-SHA256 mode or nonce-echo stub mode).
module tb_sha256d_nonce_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort;
  logic [607:0] header;
  logic [31:0]  nonce_start, nonce_end;
  logic [255:0] target;
  logic         core_rst_n;
  logic [639:0] core_block;
  logic [255:0] core_hash;
  logic         core_done;
  logic         busy, found, exhausted, timeout_err;
  logic [31:0]  found_nonce, cur_nonce, hashes_done;
  logic [255:0] found_hash;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] seq [$];

  always #5 clk = ~clk;

  sha256d_nonce_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .header(header),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .core_rst_n(core_rst_n), .core_block(core_block), .core_hash(core_hash),
    .core_done(core_done), .busy(busy), .found(found), .exhausted(exhausted),
    .timeout_err(timeout_err), .found_nonce(found_nonce), .found_hash(found_hash),
    .cur_nonce(cur_nonce), .hashes_done(hashes_done)
  );

  // Reference double-SHA256 used by the core model
  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] SHA_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = st;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
            st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
  endfunction

  function automatic logic [255:0] sha256d(input logic [639:0] hdr);
    logic [255:0] d1;
    d1 = sha_compress(sha_compress(SHA_IV, hdr[639:128]), {hdr[127:0], 8'h80, 312'b0, 64'd640});
    return sha_compress(SHA_IV, {d1, 8'h80, 184'b0, 64'd256});
  endfunction

  // Core model: done after stub_lat cycles out of reset, held until reset
  int           stub_lat = 5;
  logic         stub_hang = 1'b0;
  logic         stub_sha = 1'b0;
  logic [223:0] stub_hi = '0;
  logic [15:0]  stub_cnt;

  always @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      stub_cnt  <= '0;
      core_done <= 1'b0;
      core_hash <= '0;
    end else if (!stub_hang && !core_done) begin
      stub_cnt <= stub_cnt + 16'd1;
      if (int'(stub_cnt) == stub_lat - 1) begin
        core_done <= 1'b1;
        core_hash <= stub_sha ? sha256d(core_block) : {stub_hi, core_block[31:0]};
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tg);
    @(negedge clk);
    nonce_start = ns; nonce_end = ne; target = tg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs until busy drops; tallies reset-low / reset-high cycles and nonce order
  task automatic wait_idle(input int max_cyc, output int lo, output int hi);
    int n = 0;
    logic prev = 1'b0;
    lo = 0; hi = 0;
    seq.delete();
    while (busy && n < max_cyc) begin
      if (core_rst_n) hi++; else lo++;
      if (core_rst_n && !prev) seq.push_back(cur_nonce);
      prev = core_rst_n;
      @(negedge clk);
      n++;
    end
    if (busy) chk("job_bound", 256'(busy), 256'(0));
  endtask

  int lo, hi, n;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    header = '0; nonce_start = '0; nonce_end = '0; target = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_core_rst_n", 256'(core_rst_n), 256'(0));
    chk("rst_flags", 256'({found, exhausted, timeout_err}), 256'(0));
    chk("rst_counts", 256'({cur_nonce, hashes_done, found_nonce}), 256'(0));
    chk("rst_block", 256'(core_block[31:0]), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // start together with abort in IDLE is dropped
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 256'({busy, core_rst_n}), 256'(0));

    // Genesis block with the full double-SHA256 model
    header = {32'h01000000, 256'h0,
              256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
              32'h29ab5f49, 32'hffff001d};
    stub_sha = 1'b1; stub_lat = 400;
    start_job(32'h1dac2b7c, 32'h1dac2b7c, {256{1'b1}});
    chk("gen_busy", 256'(busy), 256'(1));
    wait_idle(2000, lo, hi);
    chk("gen_found", 256'({found, exhausted, timeout_err}), 256'(3'b100));
    chk("gen_nonce", 256'(found_nonce), 256'(32'h1dac2b7c));
    chk("gen_hash", found_hash, 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000);
    chk("gen_count", 256'(hashes_done), 256'(1));

    // Stub: hash = nonce, first nonce hits
    stub_sha = 1'b0; stub_lat = 5; stub_hi = '0;
    start_job(32'd0, 32'd9, 256'd2);
    wait_idle(500, lo, hi);
    chk("hit0_flags", 256'({found, exhausted}), 256'(2'b10));
    chk("hit0_nonce", 256'(found_nonce), 256'(0));
    chk("hit0_count", 256'(hashes_done), 256'(1));

    // No hit over 5..8
    start_job(32'd5, 32'd8, 256'd0);
    wait_idle(500, lo, hi);
    chk("exh_flags", 256'({found, exhausted, timeout_err}), 256'(3'b010));
    chk("exh_count", 256'(hashes_done), 256'(4));
    chk("exh_cur", 256'(cur_nonce), 256'(8));
    chk("exh_rst_cycles", 256'(lo), 256'(8));
    chk("exh_core_rst", 256'(core_rst_n), 256'(0));

    // Wrap-around sweep; high digest bits keep nonce 0 from hitting
    stub_hi = 224'h1;
    start_job(32'hFFFFFFFE, 32'h00000001, 256'd0);
    wait_idle(500, lo, hi);
    chk("wrap_flags", 256'({found, exhausted}), 256'(2'b01));
    chk("wrap_count", 256'(hashes_done), 256'(4));
    chk("wrap_len", 256'(seq.size()), 256'(4));
    if (seq.size() == 4)
      chk("wrap_order", 256'({seq[0], seq[1], seq[2], seq[3]}),
          256'({32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1}));

    // Core never finishes
    stub_hang = 1'b1;
    start_job(32'd20, 32'd30, 256'd0);
    wait_idle(3000, lo, hi);
    chk("to_flags", 256'({found, exhausted, timeout_err}), 256'(3'b001));
    chk("to_wait_cycles", 256'(hi), 256'(1023));
    chk("to_idle", 256'({busy, core_rst_n}), 256'(0));
    chk("to_count", 256'(hashes_done), 256'(0));
    stub_hang = 1'b0;

    // Abort in the same cycle the second digest becomes visible
    start_job(32'd5, 32'd8, 256'd0);
    n = 0;
    while (!(core_done && hashes_done == 32'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", 256'(n < 200), 256'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 256'({busy, core_rst_n}), 256'(0));
    chk("abort_flags", 256'({found, exhausted, timeout_err}), 256'(0));
    chk("abort_hold", 256'({cur_nonce, hashes_done}), 256'({32'd6, 32'd1}));
    repeat (3) @(negedge clk);
    chk("abort_stay", 256'({busy, hashes_done}), 256'({1'b0, 32'd1}));

    // Restart clears counters; start during RSTC and WAIT is ignored
    start_job(32'd5, 32'd8, 256'd0);
    chk("restart", 256'({busy, cur_nonce, hashes_done}), 256'({1'b1, 32'd5, 32'd0}));
    nonce_start = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_rstc", 256'(cur_nonce), 256'(5));
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_wait", 256'({busy, cur_nonce}), 256'({1'b1, 32'd5}));
    wait_idle(500, lo, hi);
    chk("restart_exh", 256'({exhausted, hashes_done}), 256'({1'b1, 32'd4}));

    // Hit in the middle of a range
    stub_hi = '0;
    start_job(32'd7, 32'd9, 256'd8);
    wait_idle(500, lo, hi);
    chk("hit7", 256'({found, found_nonce, hashes_done}), 256'({1'b1, 32'd7, 32'd1}));
    chk("hit7_hash", found_hash, 256'd7);

    // Asynchronous reset while waiting on the core
    stub_hi = 224'h1;
    start_job(32'd3, 32'd9, 256'd0);
    n = 0;
    while (!core_rst_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("pre_rst_wait", 256'({busy, core_rst_n}), 256'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", 256'({busy, core_rst_n, found, exhausted, timeout_err}), 256'(0));
    chk("arst_vals", 256'({found_nonce, cur_nonce, hashes_done}), 256'(0));
    chk("arst_hash", found_hash, 256'(0));
    chk("arst_block", core_block[255:0], 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
